// File: rtl/lsu_core.sv
// lsu_core: load/store unit with a private byte-addressable, little-endian data memory.
// Build option: define LSU_MEM_RESET_EN to clear the memory on reset; otherwise it is a plain RAM.
module lsu_core #(
    parameter int ADDRESS_SPACE  = 4096,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_DATA_TYPES = 6
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [$clog2(ADDRESS_SPACE)-1:0]  addr_in,
    input  logic [DATA_WIDTH-1:0]             data_in,
    input  logic                              WE_in,
    input  logic [$clog2(NUM_DATA_TYPES)-1:0] dtypes_in,
    output logic [DATA_WIDTH-1:0]             data_out
);
    localparam int AW = $clog2(ADDRESS_SPACE);
    localparam int TW = $clog2(NUM_DATA_TYPES);

    localparam logic [TW-1:0] DT_BYTE   = TW'(0);
    localparam logic [TW-1:0] DT_HALF   = TW'(1);
    localparam logic [TW-1:0] DT_WORD   = TW'(2);
    localparam logic [TW-1:0] DT_BYTE_U = TW'(3);
    localparam logic [TW-1:0] DT_HALF_U = TW'(4);

    logic [7:0]            mem [0:ADDRESS_SPACE-1];
    logic [AW-1:0]         byte_addr [4];
    logic [7:0]            rd_byte [4];
    logic [3:0]            byte_en;
    logic [DATA_WIDTH-1:0] load_val;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic [DATA_WIDTH-1:0] data_out_d;

    // Byte k of an access lives at addr+k; the adder's natural width gives the wrap.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            byte_addr[k] = addr_in + AW'(k);
            rd_byte[k]   = mem[byte_addr[k]];
        end
    end

    always_comb begin
        byte_en = 4'b0000;
        case (dtypes_in)
            DT_BYTE, DT_BYTE_U: byte_en = 4'b0001;
            DT_HALF, DT_HALF_U: byte_en = 4'b0011;
            DT_WORD:            byte_en = 4'b1111;
            default:            byte_en = 4'b0000;
        endcase
    end

    always_comb begin
        load_val = '0;
        case (dtypes_in)
            DT_BYTE:   load_val = {{24{rd_byte[0][7]}}, rd_byte[0]};
            DT_BYTE_U: load_val = {24'h000000, rd_byte[0]};
            DT_HALF:   load_val = {{16{rd_byte[1][7]}}, rd_byte[1], rd_byte[0]};
            DT_HALF_U: load_val = {16'h0000, rd_byte[1], rd_byte[0]};
            DT_WORD:   load_val = {rd_byte[3], rd_byte[2], rd_byte[1], rd_byte[0]};
            default:   load_val = '0;
        endcase
        data_out_d = WE_in ? data_out_q : load_val;
    end

`ifdef LSU_MEM_RESET_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ADDRESS_SPACE; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (WE_in) begin
            for (int k = 0; k < 4; k++) begin
                if (byte_en[k]) mem[byte_addr[k]] <= data_in[8*k +: 8];
            end
        end
    end
`else
    // Reset only gates writes here so the array stays an inferable RAM.
    always_ff @(posedge clk) begin
        if (reset_n && WE_in) begin
            for (int k = 0; k < 4; k++) begin
                if (byte_en[k]) mem[byte_addr[k]] <= data_in[8*k +: 8];
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) data_out_q <= '0;
        else          data_out_q <= data_out_d;
    end

    assign data_out = data_out_q;
endmodule

// File: tb/tb_lsu_core.sv
// Self-checking bench for lsu_core: directed word/half/byte/edge cases, mid-run reset,
// then a randomized load/store mix against a byte-level reference model.
module tb_lsu_core;
    localparam logic [2:0] T_B  = 3'd0;
    localparam logic [2:0] T_H  = 3'd1;
    localparam logic [2:0] T_W  = 3'd2;
    localparam logic [2:0] T_BU = 3'd3;
    localparam logic [2:0] T_HU = 3'd4;
    localparam logic [2:0] T_X  = 3'd7;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [11:0] addr_in;
    logic [31:0] data_in;
    logic        WE_in;
    logic [2:0]  dtypes_in;
    logic [31:0] data_out;

    logic [31:0] exp_q[$];
    logic [31:0] last_out;
    logic [7:0]  model_mem [0:255];
    int          checks = 0;
    int          errors = 0;

    lsu_core dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .addr_in   (addr_in),
        .data_in   (data_in),
        .WE_in     (WE_in),
        .dtypes_in (dtypes_in),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [11:0] a, input logic [31:0] d,
                         input logic [2:0] t);
        @(negedge clk);
        WE_in     = we;
        addr_in   = a;
        data_in   = d;
        dtypes_in = t;
    endtask

    // A store must leave data_out at the last load result.
    task automatic do_store(input logic [11:0] a, input logic [31:0] d, input logic [2:0] t);
        drive(1'b1, a, d, t);
        exp_q.push_back(last_out);
        @(posedge clk);
        #1 check_val("st_hold", data_out, exp_q.pop_front());
    endtask

    task automatic do_load(input string tag, input logic [11:0] a, input logic [2:0] t,
                           input logic [31:0] exp);
        drive(1'b0, a, 32'h0, t);
        exp_q.push_back(exp);
        last_out = exp;
        @(posedge clk);
        #1 check_val(tag, data_out, exp_q.pop_front());
    endtask

    // Reference model covers addresses 0x100..0x1FF only.
    function automatic logic [31:0] ref_load(input logic [11:0] a, input logic [2:0] t);
        int         off;
        logic [7:0] b0, b1, b2, b3;
        off = int'(a) - 'h100;
        b0 = model_mem[off];
        b1 = model_mem[off + 1];
        b2 = model_mem[off + 2];
        b3 = model_mem[off + 3];
        case (t)
            T_B:     return {{24{b0[7]}}, b0};
            T_BU:    return {24'h0, b0};
            T_H:     return {{16{b1[7]}}, b1, b0};
            T_HU:    return {16'h0, b1, b0};
            T_W:     return {b3, b2, b1, b0};
            default: return 32'h0;
        endcase
    endfunction

    task automatic ref_store(input logic [11:0] a, input logic [31:0] d, input logic [2:0] t);
        int n;
        int off;
        off = int'(a) - 'h100;
        case (t)
            T_B, T_BU: n = 1;
            T_H, T_HU: n = 2;
            T_W:       n = 4;
            default:   n = 0;
        endcase
        for (int k = 0; k < n; k++) model_mem[off + k] = d[8*k +: 8];
    endtask

    initial begin
        logic [31:0] d;
        logic [11:0] a;
        logic [2:0]  t;

        reset_n   = 1'b0;
        WE_in     = 1'b1;
        addr_in   = 12'h000;
        data_in   = 32'h0;
        dtypes_in = T_X;
        last_out  = 32'h0;

        #3 check_val("rst_async", data_out, 32'h0);
        repeat (2) @(posedge clk);
        #1 check_val("rst_hold", data_out, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1 check_val("rst_release", data_out, 32'h0);

        do_store(12'h000, 32'hABCDEF00, T_W);
        do_store(12'h004, 32'h00000010, T_W);
        do_store(12'h008, 32'hA0000F12, T_W);
        do_store(12'h00C, 32'hC0000B00, T_W);
        do_load("lw_000", 12'h000, T_W, 32'hABCDEF00);
        do_load("lw_004", 12'h004, T_W, 32'h00000010);
        do_load("lw_008", 12'h008, T_W, 32'hA0000F12);
        do_load("lw_00c", 12'h00C, T_W, 32'hC0000B00);

        do_store(12'h020, 32'h55667788, T_W);
        do_load("lw_020", 12'h020, T_W, 32'h55667788);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 check_val("rst_mid_async", data_out, 32'h0);
        drive(1'b1, 12'h020, 32'hDEADBEEF, T_W);
        @(posedge clk);
        #1 check_val("rst_st_ign", data_out, 32'h0);
        drive(1'b0, 12'h000, 32'h0, T_W);
        @(posedge clk);
        #1 check_val("rst_ld_ign", data_out, 32'h0);
        drive(1'b1, 12'h000, 32'h0, T_X);
        reset_n  = 1'b1;
        last_out = 32'h0;
        @(posedge clk);
        #1 check_val("rst_mid_rel", data_out, 32'h0);
`ifdef LSU_MEM_RESET_EN
        do_load("rst_mem000", 12'h000, T_W, 32'h00000000);
        do_load("rst_mem020", 12'h020, T_W, 32'h00000000);
`else
        do_load("rst_mem000", 12'h000, T_W, 32'hABCDEF00);
        do_load("rst_mem020", 12'h020, T_W, 32'h55667788);
`endif

        do_store(12'h010, 32'h0000ABCD, T_H);
        do_store(12'h012, 32'h0000FFFF, T_H);
        do_load("lh_010", 12'h010, T_H, 32'hFFFFABCD);
        do_load("lh_012", 12'h012, T_H, 32'hFFFFFFFF);
        do_load("lw_010", 12'h010, T_W, 32'hFFFFABCD);
        do_load("lhu_012", 12'h012, T_HU, 32'h0000FFFF);

        do_store(12'h018, 32'h00001001, T_H);
        do_store(12'h01A, 32'h000000AB, T_B);
        do_store(12'h01B, 32'h000000CB, T_B);
        do_store(12'h01C, 32'h000000EF, T_BU);
        do_store(12'h01D, 32'h00000011, T_B);
        do_load("lb_01b", 12'h01B, T_B, 32'hFFFFFFCB);
        do_load("lbu_01b", 12'h01B, T_BU, 32'h000000CB);
        do_load("lb_01d", 12'h01D, T_B, 32'h00000011);
        do_load("lh_018_iso", 12'h018, T_H, 32'h00001001);
        do_load("lw_01a", 12'h01A, T_W, 32'h11EFCBAB);

        do_store(12'h040, 32'h00000000, T_W);
        do_store(12'h044, 32'h00000000, T_W);
        do_store(12'h040, 32'hFFFFFF5A, T_B);
        do_store(12'h044, 32'hAAAA1234, T_H);
        do_load("sb_upper_ign", 12'h040, T_W, 32'h0000005A);
        do_load("sh_upper_ign", 12'h044, T_W, 32'h00001234);

        do_store(12'h051, 32'hCAFEBABE, T_W);
        do_load("lw_misalign", 12'h051, T_W, 32'hCAFEBABE);
        do_load("lh_misalign", 12'h053, T_H, 32'hFFFFCAFE);

        do_store(12'hFFE, 32'h11223344, T_W);
        do_load("lw_wrap", 12'hFFE, T_W, 32'h11223344);
        do_load("lbu_wrap0", 12'h000, T_BU, 32'h00000022);
        do_load("lhu_wrap", 12'hFFF, T_HU, 32'h00002233);

        do_store(12'h030, 32'h12345678, T_W);
        do_store(12'h030, 32'hFFFFFFFF, T_X);
        do_store(12'h030, 32'hFFFFFFFF, 3'd5);
        do_load("inv_st_nochg", 12'h030, T_W, 32'h12345678);
        do_load("inv_ld_7", 12'h030, T_X, 32'h0);
        do_load("lw_030", 12'h030, T_W, 32'h12345678);
        do_load("inv_ld_6", 12'h030, 3'd6, 32'h0);

        for (int i = 0; i < 64; i++) begin
            d = $urandom;
            a = 12'h100 + 12'(4 * i);
            do_store(a, d, T_W);
            ref_store(a, d, T_W);
        end
        for (int n = 0; n < 120; n++) begin
            t = 3'($urandom_range(0, 7));
            a = 12'h100 + 12'($urandom_range(0, 252));
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                do_store(a, d, t);
                ref_store(a, d, t);
            end else begin
                do_load("rnd_ld", a, t, ref_load(a, t));
            end
        end

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sb_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
